// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port multi-cycle memory; one access in flight at a time.
// Latency: grant in c0, memory busy c1..cL, one-cycle response pulse in c(L+1), idle again c(L+2).
// Backpressure: reqN_ready is combinational and only asserted in IDLE; ARB_ROUND_ROBIN_EN selects RR vs fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int            CW  = $clog2(MEM_LATENCY + 1);
  localparam logic [CW-1:0] LAT = CW'(MEM_LATENCY);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                own_q, own_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                gnt0, gnt1;
  logic                hs0, hs1;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // Round robin: on contention the port that did not win last time is chosen.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | last_grant_q);
    gnt1 = req1_valid & (~req0_valid | ~last_grant_q);
  end

  // Remember the winner of every handshake.
  always_comb begin
    last_grant_d = last_grant_q;
    if (hs0)      last_grant_d = 1'b0;
    else if (hs1) last_grant_d = 1'b1;
  end

  // last_grant resets to 1 so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: port 1 only gets in when port 0 is not asking.
  always_comb begin
    gnt0 = req0_valid;
    gnt1 = req1_valid & ~req0_valid;
  end
`endif

  // Next-state, handshake and per-state outputs of the access sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    own_d      = own_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    mem_we     = 1'b0;
    hs0        = 1'b0;
    hs1        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Ready is masked during reset so nothing looks accepted that will be discarded.
        req0_ready = rst_n & gnt0;
        req1_ready = rst_n & gnt1;
        hs0        = req0_valid & req0_ready;
        hs1        = req1_valid & req1_ready;
        if (hs0 | hs1) begin
          own_d   = hs1;
          we_d    = hs1 ? req1_we    : req0_we;
          addr_d  = hs1 ? req1_addr  : req0_addr;
          wdata_d = hs1 ? req1_wdata : req0_wdata;
          cnt_d   = LAT;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // Write strobe only on the first access cycle, while counter still holds L.
        mem_we = we_q & (cnt_q == LAT);
        cnt_d  = cnt_q - ONE;
        if (cnt_q == ONE) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (own_q) rdata1_d = mem_rdata;
            else       rdata0_d = mem_rdata;
          end
        end
      end
      ST_RESP: begin
        rsp0_valid = ~own_q;
        rsp1_valid = own_q;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      own_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      own_q    <= own_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // The latched request drives memory directly, so address/data hold between accesses.
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign rsp0_rdata = rdata0_q;
  assign rsp1_rdata = rdata1_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
